// File: rtl/cpu_ctrl_pkg.sv
// Shared types and defaults for the pipeline control blocks.
package cpu_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam int REG_W = 5;
    localparam logic [4:0] ZERO_REG = 5'd0;
    localparam int MC_LATENCY = 4;

endpackage

// File: rtl/hazard_stall_ctrl_mc_wait_timer.sv
// Down-counter that times the frozen window of a multi-cycle EX operation.
module mc_wait_timer #(
    parameter int MC_LATENCY = cpu_ctrl_pkg::MC_LATENCY,
    localparam int CNT_W = $clog2(MC_LATENCY) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MC_LATENCY - 1);

    logic [CNT_W-1:0] mc_cnt;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc_cnt <= '0;
        end else if (load) begin
            mc_cnt <= LOAD_VAL;
        end else if (dec && mc_cnt != '0) begin
            mc_cnt <= mc_cnt - 1'b1;
        end
    end

    // The last wait cycle is the one entered with a count of one.
    assign done = (mc_cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use stalls, redirect flushes, multi-cycle
// EX freeze and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_W      = cpu_ctrl_pkg::REG_W,
    parameter int MC_LATENCY = cpu_ctrl_pkg::MC_LATENCY,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_id,
    input  logic [REG_W-1:0]  rt_id,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              id_mc_start,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              mc_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [PERF_W-1:0] STALL_MAX = '1;

    state_t state;
    logic   load_use;
    logic   mc_issue;
    logic   mc_done;

    assign load_use = ex_mem_read && (ex_rt != REG_W'(ZERO_REG)) &&
                      ((ex_rt == rs_id) || (id_uses_rt && ex_rt == rt_id));

    // NOTE: every output gets a default before the branches so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        mc_busy     = 1'b0;
        mc_issue    = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == MC_WAIT) begin
            // EX holds only the mc op or bubbles, so redirects and hazards are moot.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            mc_busy     = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_jump) begin
            ifid_flush  = 1'b1;
        end else if (id_mc_start && MC_LATENCY > 1) begin
            // The op itself issues to EX; the front end holds behind it.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            mc_issue    = 1'b1;
        end
    end

    mc_wait_timer #(
        .MC_LATENCY (MC_LATENCY)
    ) u_mc_wait_timer (
        .clk   (clk),
        .reset (reset),
        .load  (mc_issue),
        .dec   (state == MC_WAIT),
        .done  (mc_done)
    );

    // NOTE: only control state is reset here; there is no storage array that
    // would need (or should get) a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            stall_cycles <= '0;
        end else begin
            case (state)
                RUN:     if (mc_issue) state <= MC_WAIT;
                MC_WAIT: if (mc_done)  state <= RUN;
                default: state <= RUN;
            endcase
            if (!pc_write && stall_cycles != STALL_MAX) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed vectors, per-cycle comparison against a
// behavioural model, plus hand-computed checkpoints.
module tb_hazard_stall_ctrl;

    localparam int REG_W     = 5;
    localparam int MC_LAT    = 4;
    localparam int PERF_W    = 4;
    localparam int STALL_MAX = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_W-1:0]  rs_id, rt_id, ex_rt;
    logic              id_uses_rt, id_jump, id_mc_start, ex_mem_read, ex_branch_taken;
    logic              pc_write, ifid_write, ifid_flush, idex_bubble, mc_busy;
    logic [PERF_W-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Model state: remaining frozen wait cycles and the stall count.
    int m_freeze = 0;
    int m_stall  = 0;

    hazard_stall_ctrl #(
        .REG_W      (REG_W),
        .MC_LATENCY (MC_LAT),
        .PERF_W     (PERF_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .id_uses_rt      (id_uses_rt),
        .id_jump         (id_jump),
        .id_mc_start     (id_mc_start),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mc_busy         (mc_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pc_write, ifid_write, ifid_flush, idex_bubble, mc_busy}.
    function automatic logic [4:0] model_outs(input int freeze);
        logic hazard;
        hazard = ex_mem_read && ex_rt != 0 &&
                 (ex_rt == rs_id || (id_uses_rt && ex_rt == rt_id));
        if (reset)            return 5'b00110;
        if (freeze > 0)       return 5'b00011;
        if (ex_branch_taken)  return 5'b11110;
        if (hazard)           return 5'b00010;
        if (id_jump)          return 5'b11100;
        if (id_mc_start)      return (MC_LAT > 1) ? 5'b00000 : 5'b11000;
        return 5'b11000;
    endfunction

    always @(posedge clk or posedge reset) begin
        logic [4:0] o;
        if (reset) begin
            m_freeze = 0;
            m_stall  = 0;
        end else begin
            o = model_outs(m_freeze);
            if (!o[4] && m_stall < STALL_MAX) m_stall++;
            if (m_freeze > 0)       m_freeze--;
            else if (o == 5'b00000) m_freeze = MC_LAT - 1;
        end
    end

    always @(negedge clk) begin
        check("outs", {27'd0, pc_write, ifid_write, ifid_flush, idex_bubble, mc_busy},
              {27'd0, model_outs(m_freeze)});
        check("stall_model", {28'd0, stall_cycles}, m_stall);
    end

    task automatic idle();
        rs_id = 5'd1; rt_id = 5'd2; ex_rt = 5'd3;
        id_uses_rt = 1'b0; id_jump = 1'b0; id_mc_start = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #3;
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_ifid_write", ifid_write, 1'b0);
        check("rst_flush", ifid_flush, 1'b1);
        check("rst_bubble", idex_bubble, 1'b1);
        check("rst_busy", mc_busy, 1'b0);
        check("rst_stall", stall_cycles, 0);
        cyc();
        reset = 1'b0;
        #3;
        check("dflt_pc_write", pc_write, 1'b1);

        // Load-use on rs: one stall cycle, then resume.
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd8; rs_id = 5'd8;
        #3;
        check("lu_pc_write", pc_write, 1'b0);
        check("lu_ifid_write", ifid_write, 1'b0);
        check("lu_bubble", idex_bubble, 1'b1);
        check("lu_flush", ifid_flush, 1'b0);
        cyc();
        idle();
        #3;
        check("lu_resume", pc_write, 1'b1);
        check("lu_stall_cnt", stall_cycles, 1);

        // Register zero never creates a hazard.
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd0; rs_id = 5'd0;
        #3;
        check("r0_no_stall", pc_write, 1'b1);
        // rt only matters when the ID instruction reads it.
        cyc();
        ex_rt = 5'd9; rt_id = 5'd9; rs_id = 5'd3; id_uses_rt = 1'b0;
        #3;
        check("rt_unused", pc_write, 1'b1);
        cyc();
        id_uses_rt = 1'b1;
        #3;
        check("rt_used", pc_write, 1'b0);

        // Taken branch beats load-use and jump.
        cyc();
        ex_mem_read = 1'b1; ex_rt = 5'd8; rs_id = 5'd8; id_jump = 1'b1; ex_branch_taken = 1'b1;
        #3;
        check("br_pc_write", pc_write, 1'b1);
        check("br_flush", ifid_flush, 1'b1);
        check("br_bubble", idex_bubble, 1'b1);
        cyc();
        idle();
        id_jump = 1'b1;
        #3;
        check("br_stall_cnt", stall_cycles, 2);
        check("jmp_flush", ifid_flush, 1'b1);
        check("jmp_bubble", idex_bubble, 1'b0);

        // Multi-cycle op: four frozen cycles counting the issue cycle.
        cyc();
        idle();
        id_mc_start = 1'b1;
        #3;
        check("mc_issue_bubble", idex_bubble, 1'b0);
        check("mc_issue_pc", pc_write, 1'b0);
        check("mc_issue_busy", mc_busy, 1'b0);
        for (int i = 0; i < MC_LAT - 1; i++) begin
            cyc();
            ex_branch_taken = (i == 0);
            id_mc_start = (i == 0);
            #3;
            check("mc_wait_busy", mc_busy, 1'b1);
            check("mc_wait_bubble", idex_bubble, 1'b1);
            check("mc_wait_flush", ifid_flush, 1'b0);
            check("mc_wait_pc", pc_write, 1'b0);
        end
        cyc();
        idle();
        #3;
        check("mc_done_pc", pc_write, 1'b1);
        check("mc_done_busy", mc_busy, 1'b0);
        check("mc_stall_cnt", stall_cycles, 6);

        // Asynchronous reset in the middle of the wait window.
        cyc();
        id_mc_start = 1'b1;
        cyc();
        id_mc_start = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check("arst_busy", mc_busy, 1'b0);
        check("arst_stall", stall_cycles, 0);
        check("arst_flush", ifid_flush, 1'b1);
        check("arst_pc", pc_write, 1'b0);
        cyc();
        reset = 1'b0;
        #3;
        check("arst_rel_pc", pc_write, 1'b1);
        check("arst_rel_busy", mc_busy, 1'b0);
        check("arst_rel_flush", ifid_flush, 1'b0);

        // Counter saturates instead of wrapping.
        reset_dut();
        ex_mem_read = 1'b1; ex_rt = 5'd8; rs_id = 5'd8;
        repeat (20) cyc();
        #3;
        check("sat_hold", stall_cycles, 15);
        cyc();
        idle();
        cyc();
        #3;
        check("sat_after", stall_cycles, 15);

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard and stall controller for the 5-stage core. It drives the write-enable and flush of the IF/ID pipeline register and the PC, and injects bubbles into ID/EX. It resolves load-use hazards, taken-branch and jump redirects, and multi-cycle EX operations (mult/div), which need a registered wait FSM. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register-specifier width
MC_LATENCY, 4, total cycles the front end is frozen for one multi-cycle op (>=1)
PERF_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock; state updates on posedge
reset  in  1  asynchronous, active-high
rs_id  in  REG_W  rs field of instruction held in IF/ID
rt_id  in  REG_W  rt field of instruction held in IF/ID
id_uses_rt  in  1  ID instruction reads rt as a source
id_jump  in  1  ID instruction is an unconditional jump
id_mc_start  in  1  ID instruction is a multi-cycle op
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  destination of the load in EX
ex_branch_taken  in  1  branch in EX resolved taken
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID clears to NOP (wins over ifid_write)
idex_bubble  out  1  ID/EX loads control bubble
mc_busy  out  1  FSM in MC_WAIT
stall_cycles  out  PERF_W  saturating count of cycles with pc_write=0

Behaviour:
- State register: RUN, MC_WAIT. Down-counter mc_cnt, width clog2(MC_LATENCY)+1.
- Outputs are combinational from state and current inputs (Mealy). State, mc_cnt and stall_cycles are registered.
- Reset asserted (async, any state including mid-MC_WAIT):
  - state=RUN, mc_cnt=0, stall_cycles=0.
  - While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, mc_busy=0.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==rs_id) | (id_uses_rt & ex_rt==rt_id)).
- RUN, priority high→low:
  1. ex_branch_taken:
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1.
     - Wins over load_use, jump and mc_start in the same cycle. Stay RUN.
  2. load_use:
     - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
     - Exactly one stall cycle per hazard; re-evaluated the next cycle. Stay RUN.
  3. id_jump:
     - pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0 (the jump proceeds). Stay RUN.
  4. id_mc_start:
     - idex_bubble=0 (the op issues to EX), pc_write=0, ifid_write=0.
     - If MC_LATENCY>1: mc_cnt<=MC_LATENCY-1 and go to MC_WAIT.
     - If MC_LATENCY==1: behave as default (pc_write=1, ifid_write=1) and stay RUN.
  5. default: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- MC_WAIT:
  - pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, mc_busy=1.
  - mc_cnt decrements each cycle. When mc_cnt==1, next state is RUN.
  - ex_branch_taken, id_jump, load_use and id_mc_start are all ignored, since EX holds only the mc op or bubbles.
  - Front end is frozen for exactly MC_LATENCY cycles, counting the issue cycle.
- stall_cycles:
  - Increments on each posedge where reset=0 and pc_write=0.
  - Saturates at all-ones with no wrap.
- The IF/ID instruction is never lost on a stall: ifid_write=0 holds it, and the redirect paths are the only ones that flush.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - state enum {RUN=0, MC_WAIT=1}
  - REG_W
  - ZERO_REG=5'd0
  - MC_LATENCY default
- One natural sub-module: mc_wait_timer (load/decrement/done counter, parameterized by MC_LATENCY).
- The saturating perf counter stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, rs_id=8 → one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Next cycle (ex_mem_read=0) → pc_write=1. stall_cycles=1.
- rt=0 filter and id_uses_rt: ex_rt=0, rs_id=0 → no stall. ex_rt=9, rt_id=9, id_uses_rt=0 → no stall; with id_uses_rt=1 → stall.
- Branch priority: ex_branch_taken=1 together with load_use=1 and id_jump=1 → pc_write=1, ifid_flush=1, idex_bubble=1, no stall counted.
- Multi-cycle, MC_LATENCY=4: id_mc_start=1 → issue cycle idex_bubble=0, pc_write=0. Then 3 cycles in MC_WAIT (mc_busy=1, idex_bubble=1). Cycle 5 → RUN with pc_write=1. stall_cycles=4.
- Reset mid-MC_WAIT: assert reset asynchronously after 1 wait cycle → state=RUN, mc_busy=0, stall_cycles=0 immediately. While reset is high, ifid_flush=1 and pc_write=0. After release, default outputs resume.
- Saturation, PERF_W=4: hold load_use for 20 cycles → stall_cycles stops at 15 with no wrap.
